// File: rtl/spi_led_frame_rx_if.sv
// spi_led_frame_rx_if: serial input pair and decoded LED-strip outputs.
// Optional macro SPI_LED_RX_STATS_EN adds the led_count/err_count outputs.
interface spi_led_frame_rx_if #(
    parameter int unsigned IDX_W = 8
);
    logic             sck;
    logic             mosi;
    logic             led_valid;
    logic [IDX_W-1:0] led_index;
    logic [4:0]       led_bright;
    logic [7:0]       led_blue;
    logic [7:0]       led_green;
    logic [7:0]       led_red;
    logic             frame_start;
    logic             frame_done;
    logic             hdr_err;
`ifdef SPI_LED_RX_STATS_EN
    logic [15:0]      led_count;
    logic [7:0]       err_count;

    modport master (
        output sck, mosi,
        input  led_valid, led_index, led_bright, led_blue, led_green, led_red,
        input  frame_start, frame_done, hdr_err, led_count, err_count
    );
    modport slave (
        input  sck, mosi,
        output led_valid, led_index, led_bright, led_blue, led_green, led_red,
        output frame_start, frame_done, hdr_err, led_count, err_count
    );
`else
    modport master (
        output sck, mosi,
        input  led_valid, led_index, led_bright, led_blue, led_green, led_red,
        input  frame_start, frame_done, hdr_err
    );
    modport slave (
        input  sck, mosi,
        output led_valid, led_index, led_bright, led_blue, led_green, led_red,
        output frame_start, frame_done, hdr_err
    );
`endif
endinterface

// File: rtl/spi_led_frame_rx.sv
// spi_led_frame_rx: oversampling SPI receiver for the LED-strip stream.
// Hunts for a 32-zero start frame, then decodes 32-bit LED words until an
// all-ones end frame, a bad header or an sck idle timeout.
// Optional macro SPI_LED_RX_STATS_EN adds per-frame LED and error counters.
module spi_led_frame_rx #(
    parameter int unsigned IDX_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic               CLK,
    input logic               myreset,
    spi_led_frame_rx_if.slave bus
);
    typedef enum logic {HUNT, LEDS} state_t;
    typedef enum logic [2:0] {EV_NONE, EV_START, EV_LED, EV_DONE, EV_HDR} ev_t;

    localparam int unsigned      IDLE_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0]  IDX_MAX  = '1;

    logic              sck_m, sck_s, sck_d, mosi_m, mosi_s;
    logic              rise_q, bit_q;
    logic [31:0]       shift_q, shift_n, post;
    logic [4:0]        cnt_q, cnt_n;
    logic [IDLE_W-1:0] idle_q, idle_n;
    logic [IDX_W-1:0]  idx_q, idx_n, ev_idx_q, ev_idx_n;
    logic [28:0]       ev_word_q, ev_word_n;
    state_t            state_q, state_n;
    ev_t               ev_q, ev_n;

    // Two-flop synchronisers, sck rise detect, and a registered (rise, bit) pair.
    always_ff @(posedge CLK) begin
        if (!myreset) begin
            sck_m  <= 1'b0;
            sck_s  <= 1'b0;
            sck_d  <= 1'b0;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
            rise_q <= 1'b0;
            bit_q  <= 1'b0;
        end else begin
            sck_m  <= bus.sck;
            sck_s  <= sck_m;
            sck_d  <= sck_s;
            mosi_m <= bus.mosi;
            mosi_s <= mosi_m;
            rise_q <= sck_s & ~sck_d;
            if (sck_s & ~sck_d) bit_q <= mosi_s;
        end
    end

    // Decoder state register; the decoded event is held one cycle before the outputs.
    always_ff @(posedge CLK) begin
        if (!myreset) begin
            state_q   <= HUNT;
            shift_q   <= '0;
            cnt_q     <= '0;
            idle_q    <= '0;
            idx_q     <= '0;
            ev_q      <= EV_NONE;
            ev_word_q <= '0;
            ev_idx_q  <= '0;
        end else begin
            state_q   <= state_n;
            shift_q   <= shift_n;
            cnt_q     <= cnt_n;
            idle_q    <= idle_n;
            idx_q     <= idx_n;
            ev_q      <= ev_n;
            ev_word_q <= ev_word_n;
            ev_idx_q  <= ev_idx_n;
        end
    end

    // Next-state: shift on each sck rise, classify completed words, idle timeout.
    always_comb begin
        post      = {shift_q[30:0], bit_q};
        state_n   = state_q;
        shift_n   = shift_q;
        cnt_n     = cnt_q;
        idle_n    = idle_q;
        idx_n     = idx_q;
        ev_n      = EV_NONE;
        ev_word_n = post[28:0];
        ev_idx_n  = idx_q;
        if (rise_q) begin
            idle_n  = '0;
            shift_n = post;
            case (state_q)
                HUNT: begin
                    if (post == '0) begin
                        ev_n    = EV_START;
                        cnt_n   = '0;
                        idx_n   = '0;
                        state_n = LEDS;
                    end
                end
                LEDS: begin
                    cnt_n = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        // All-ones is tested first so a bright-white LED word can never mask the end frame.
                        if (post == '1) begin
                            ev_n    = EV_DONE;
                            state_n = HUNT;
                        end else if (post == '0) begin
                            ev_n  = EV_START;
                            idx_n = '0;
                        end else if (post[31:29] == 3'b111) begin
                            ev_n = EV_LED;
                            if (idx_q != IDX_MAX) idx_n = idx_q + IDX_W'(1);
                        end else begin
                            ev_n    = EV_HDR;
                            state_n = HUNT;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end else if (idle_q == IDLE_MAX) begin
            state_n = HUNT;
            cnt_n   = '0;
            shift_n = '0;
        end else begin
            idle_n = idle_q + IDLE_W'(1);
        end
    end

    // Registered output pulses, LED field load, and optional counters.
    always_ff @(posedge CLK) begin
        if (!myreset) begin
            bus.led_valid   <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.hdr_err     <= 1'b0;
            bus.led_index   <= '0;
            bus.led_bright  <= '0;
            bus.led_blue    <= '0;
            bus.led_green   <= '0;
            bus.led_red     <= '0;
`ifdef SPI_LED_RX_STATS_EN
            bus.led_count   <= '0;
            bus.err_count   <= '0;
`endif
        end else begin
            bus.led_valid   <= (ev_q == EV_LED);
            bus.frame_start <= (ev_q == EV_START);
            bus.frame_done  <= (ev_q == EV_DONE);
            bus.hdr_err     <= (ev_q == EV_HDR);
            if (ev_q == EV_LED) begin
                bus.led_index  <= ev_idx_q;
                bus.led_bright <= ev_word_q[28:24];
                bus.led_blue   <= ev_word_q[23:16];
                bus.led_green  <= ev_word_q[15:8];
                bus.led_red    <= ev_word_q[7:0];
            end
`ifdef SPI_LED_RX_STATS_EN
            if (ev_q == EV_START) bus.led_count <= '0;
            else if (ev_q == EV_LED) bus.led_count <= bus.led_count + 16'd1;
            if (ev_q == EV_HDR && bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
`endif
        end
    end
endmodule

// File: tb/tb_spi_led_frame_rx.sv
// tb_spi_led_frame_rx: drives a shared serial stream into two decoders
// (IDX_W=8 and IDX_W=2); a bit-level reference model queues expected events
// and a negedge monitor pops and compares them, including pulse latency.
module tb_spi_led_frame_rx;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Cycle counter used as the latency time base.
    always @(posedge clk) cyc <= cyc + 1;

    spi_led_frame_rx_if #(.IDX_W(8)) bus8 ();
    spi_led_frame_rx_if #(.IDX_W(2)) bus2 ();
    assign bus8.sck  = sck;
    assign bus8.mosi = mosi;
    assign bus2.sck  = sck;
    assign bus2.mosi = mosi;

    spi_led_frame_rx #(.IDX_W(8), .TIMEOUT_CYC(64)) dut8 (.CLK(clk), .myreset(rstn), .bus(bus8.slave));
    spi_led_frame_rx #(.IDX_W(2), .TIMEOUT_CYC(64)) dut2 (.CLK(clk), .myreset(rstn), .bus(bus2.slave));

    typedef struct {
        int          kind;   // 1 start, 2 led, 3 done, 4 hdr
        int          cyc;
        int          idx;
        logic [31:0] word;
        int          lc;
        int          ec;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];

    // Reference model: last 32 received bits, frame mode, bits since alignment.
    bit          m_leds;
    logic [31:0] m_hist;
    int          m_cnt, m_idx8, m_idx2, m_lc, m_ec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(input int kind, input int e0);
        exp_t e;
        e.kind = kind;
        e.cyc  = e0 + 4;
        e.word = m_hist;
        e.lc   = m_lc;
        e.ec   = m_ec;
        e.idx  = m_idx8;
        q8.push_back(e);
        e.idx  = m_idx2;
        q2.push_back(e);
    endfunction

    function automatic void model_reset();
        m_leds = 0; m_hist = '0; m_cnt = 0;
        m_idx8 = 0; m_idx2 = 0; m_lc = 0; m_ec = 0;
    endfunction

    function automatic void model_timeout();
        m_leds = 0; m_hist = '0; m_cnt = 0;
    endfunction

    function automatic void model_bit(input logic b, input int e0);
        m_hist = {m_hist[30:0], b};
        if (!m_leds) begin
            if (m_hist == 32'h0) begin
                m_leds = 1; m_cnt = 0; m_idx8 = 0; m_idx2 = 0; m_lc = 0;
                push(1, e0);
            end
        end else begin
            m_cnt++;
            if (m_cnt == 32) begin
                m_cnt = 0;
                if (m_hist == 32'hFFFF_FFFF) begin
                    m_leds = 0;
                    push(3, e0);
                end else if (m_hist == 32'h0) begin
                    m_idx8 = 0; m_idx2 = 0; m_lc = 0;
                    push(1, e0);
                end else if (m_hist[31:29] == 3'b111) begin
                    m_lc++;
                    push(2, e0);
                    if (m_idx8 < 255) m_idx8++;
                    if (m_idx2 < 3) m_idx2++;
                end else begin
                    if (m_ec < 255) m_ec++;
                    m_leds = 0;
                    push(4, e0);
                end
            end
        end
    endfunction

    // One sck period of 6 CLK: 3 low (mosi settles), 3 high.
    task automatic send_bit(input logic b);
        int e0;
        @(negedge clk);
        mosi = b;
        sck  = 1'b0;
        repeat (2) @(negedge clk);
        sck = 1'b1;
        e0  = cyc + 1;
        model_bit(b, e0);
        repeat (3) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_bits(w, 32);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        if (n >= 70) model_timeout();
    endtask

    task automatic start_frame();
        send_bits(32'hFF, 8);
        send_word(32'h0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, bus8.led_valid, 0);
        chk({tag, "_start"}, bus8.frame_start, 0);
        chk({tag, "_done"}, bus8.frame_done, 0);
        chk({tag, "_hdr"}, bus8.hdr_err, 0);
        chk({tag, "_index"}, bus8.led_index, 0);
        chk({tag, "_fields"}, {bus8.led_bright, bus8.led_blue, bus8.led_green, bus8.led_red}, 0);
        chk({tag, "_index2"}, bus2.led_index, 0);
`ifdef SPI_LED_RX_STATS_EN
        chk({tag, "_ledcnt"}, bus8.led_count, 0);
        chk({tag, "_errcnt"}, bus8.err_count, 0);
`endif
    endtask

    task automatic mon(input int inst, input logic v, input logic fs, input logic fd, input logic he,
                       input int idx, input logic [31:0] w, input int lc, input int ec);
        exp_t  e;
        int    kind;
        string p;
        p = (inst == 0) ? "w8" : "w2";
        if (!(v | fs | fd | he)) return;
        chk({p, "_onehot"}, $countones({v, fs, fd, he}), 1);
        kind = v ? 2 : fs ? 1 : fd ? 3 : 4;
        if ((inst == 0 && q8.size() == 0) || (inst == 1 && q2.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected actual=kind%0d expected=no_pulse (t=%0t)", p, kind, $time);
            return;
        end
        e = (inst == 0) ? q8.pop_front() : q2.pop_front();
        chk({p, "_kind"}, kind, e.kind);
        chk({p, "_latency"}, cyc, e.cyc);
        if (kind == 2) begin
            chk({p, "_index"}, idx, e.idx);
            chk({p, "_word"}, w, e.word);
        end
`ifdef SPI_LED_RX_STATS_EN
        if (kind == 2 || kind == 1) chk({p, "_ledcnt"}, lc, (kind == 1) ? 0 : e.lc);
        if (kind == 4) chk({p, "_errcnt"}, ec, e.ec);
`else
        if (lc != ec) chk({p, "_nostats"}, lc, ec);
`endif
    endtask

    // Monitor: pops the scoreboard whenever either decoder pulses.
    always @(negedge clk) begin
        if (rstn) begin
`ifdef SPI_LED_RX_STATS_EN
            mon(0, bus8.led_valid, bus8.frame_start, bus8.frame_done, bus8.hdr_err, int'(bus8.led_index),
                {3'b111, bus8.led_bright, bus8.led_blue, bus8.led_green, bus8.led_red},
                int'(bus8.led_count), int'(bus8.err_count));
            mon(1, bus2.led_valid, bus2.frame_start, bus2.frame_done, bus2.hdr_err, int'(bus2.led_index),
                {3'b111, bus2.led_bright, bus2.led_blue, bus2.led_green, bus2.led_red},
                int'(bus2.led_count), int'(bus2.err_count));
`else
            mon(0, bus8.led_valid, bus8.frame_start, bus8.frame_done, bus8.hdr_err, int'(bus8.led_index),
                {3'b111, bus8.led_bright, bus8.led_blue, bus8.led_green, bus8.led_red}, 0, 0);
            mon(1, bus2.led_valid, bus2.frame_start, bus2.frame_done, bus2.hdr_err, int'(bus2.led_index),
                {3'b111, bus2.led_bright, bus2.led_blue, bus2.led_green, bus2.led_red}, 0, 0);
`endif
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          n, r;
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_zero("reset");
        idle(100);
        check_zero("idle");

        // Two LEDs between start and end frames.
        start_frame();
        send_word(32'hE510_2030);
        send_word(32'hFF00_00FF);
        send_word(32'hFFFF_FFFF);
        idle(100);
        chk("hold_fields", {bus8.led_bright, bus8.led_blue, bus8.led_green, bus8.led_red}, {5'd31, 24'h0000FF});
        chk("hold_index", bus8.led_index, 1);

        // Bad header, then an LED word that must be ignored.
        start_frame();
        send_word(32'h5A00_0000);
        send_word(32'hE101_0101);
        idle(100);

        // Partial word dropped by timeout, then a fresh frame.
        start_frame();
        send_bits(32'hE712_3456 >> 16, 16);
        idle(100);
        start_frame();
        send_word(32'hE7AA_BBCC);
        send_word(32'hFFFF_FFFF);
        idle(100);

        // Reset in the middle of an LED word.
        start_frame();
        send_bits(32'hE7AA, 16);
        idle(5);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        @(negedge clk);
        check_zero("midreset");
        send_bits(32'hFF00, 16);
        idle(100);

        // Six LEDs (index saturation on the narrow decoder), then one bad header.
        start_frame();
        for (int i = 0; i < 6; i++) begin
            w = {3'b111, 29'($urandom)};
            send_word(w);
        end
        send_word(32'h1234_5678);
        idle(100);
`ifdef SPI_LED_RX_STATS_EN
        chk("stats_ledcnt", bus8.led_count, 6);
        chk("stats_errcnt", bus8.err_count, 1);
`endif

        // Randomised frames.
        for (int f = 0; f < 12; f++) begin
            start_frame();
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 99);
                if (r < 85)      w = {3'b111, 29'($urandom)};
                else if (r < 92) w = {3'($urandom_range(0, 6)), 29'($urandom)};
                else             w = 32'h0;
                send_word(w);
            end
            send_word(32'hFFFF_FFFF);
            idle(($urandom_range(0, 1) == 1) ? 100 : 12);
        end
        idle(100);

        chk("q8_drained", q8.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_led_frame_rx.md
Name: spi_led_frame_rx

Overview:
- SPI receive-side decoder for the LED-strip serial stream (mosi/sck, MSB-first, data valid on sck rising edge).
- Oversamples sck/mosi on the system CLK and deserialises 32-bit words.
- Decodes start frame (32 zero bits), LED frames (3'b111 header, 5-bit brightness, blue, green, red) and end frame (all ones).
- Sits in bench/loopback builds and in downstream strip-emulation logic, consuming what the transmitter drives.

Parameters:
- IDX_W, 8, width of the LED index counter.
- TIMEOUT_CYC, 64, CLK cycles with no sck rising edge before the decoder drops back to HUNT.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- myreset  in  1  synchronous reset, active-low.
- sck  in  1  serial clock from transmitter, asynchronous to CLK.
- mosi  in  1  serial data from transmitter.
- led_valid  out  1  one-cycle pulse: LED fields updated.
- led_index  out  IDX_W  position of the LED in the current frame, 0-based.
- led_bright  out  5  brightness field.
- led_blue  out  8  blue byte.
- led_green  out  8  green byte.
- led_red  out  8  red byte.
- frame_start  out  1  one-cycle pulse: start frame recognised.
- frame_done  out  1  one-cycle pulse: end frame recognised.
- hdr_err  out  1  one-cycle pulse: LED word with a bad header.

Behaviour:
- Reset (myreset==0 at a CLK edge): all outputs 0, shift register 0, bit counter 0, idle counter 0, state HUNT. Reset mid-word discards the partial word.
- Synchronisation and edge detect:
  - sck and mosi each pass through 2 flops; a 3rd sck flop feeds edge detect.
  - edge = sck_s & ~sck_d.
  - mosi_s is sampled on the edge cycle.
  - Requires sck high and low for at least 2 CLK cycles each.
- Shift: on edge, shift = {shift[30:0], mosi_s}.
- HUNT:
  - Shifts continuously with no word alignment.
  - When the post-shift value is 32'h0: pulse frame_start, clear bit counter and led_index, go to LEDS.
- LEDS:
  - Bit counter increments on each edge; on the 32nd bit (counter wraps 31->0) the completed word W is evaluated.
  - W==32'hFFFFFFFF: pulse frame_done, go to HUNT. All-ones always takes priority over an LED word with brightness 31 and white colour.
  - W==32'h0: repeated start. Pulse frame_start, led_index=0, stay in LEDS.
  - W[31:29]==3'b111:
    - Load led_bright=W[28:24], led_blue=W[23:16], led_green=W[15:8], led_red=W[7:0].
    - Pulse led_valid with led_index equal to this LED's position.
    - Post-increment led_index, saturating at 2^IDX_W-1. Further LEDs reuse the saturated index.
  - Otherwise: pulse hdr_err, go to HUNT.
- Timeout:
  - The idle counter clears on every edge and otherwise increments, saturating.
  - On reaching TIMEOUT_CYC: state HUNT, bit counter 0, shift 0. No pulse is generated.
- Latency: pulses are registered.
  - led_valid, frame_start, frame_done and hdr_err rise exactly 4 CLK edges after the first CLK edge that samples raw sck high for the completing bit.
  - Each pulse lasts exactly 1 cycle.
- Data outputs hold their last values between led_valid pulses.
- At most one of the four pulses is high in any cycle.

Optional Feature:
- Macro: SPI_LED_RX_STATS_EN.
- Defined: adds outputs led_count[15:0] (LED words decoded in the current frame, cleared on frame_start) and err_count[7:0] (hdr_err events since reset, saturating at 255).
  - Both are 0 at reset.
  - Both update on the same cycle as the corresponding pulse.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then idle sck low for 100 CLK -> all outputs 0, no pulses.
- Start frame, LED words 0xE5102030 and 0xFF0000FF, then end frame.
  - Response: frame_start once; led_valid with index 0, bright 5, B 0x10, G 0x20, R 0x30; then led_valid with index 1, bright 31, B 0x00, G 0x00, R 0xFF; then frame_done once.
  - Each pulse arrives 4 CLK after the final sck rise of its word.
- Start frame, then word 0x5A000000 -> hdr_err pulse.
  - A following 0xE1010101 produces no led_valid until a new start frame is sent.
- Start frame, 16 bits of an LED word, sck idle for 70 CLK, then new start frame plus 0xE7AABBCC.
  - Response: partial word dropped; led_valid with index 0, bright 7, B 0xAA, G 0xBB, R 0xCC.
- myreset low for 1 cycle mid-LED-word -> outputs 0, state HUNT; the remaining bits do not produce led_valid.
- IDX_W=2: start frame plus 6 LED words -> indices 0,1,2,3,3,3.
  - With SPI_LED_RX_STATS_EN defined: led_count=6; after one bad header, err_count=1.
